// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: frame-tracking states, parity encodings and legal
// frame-shape ranges used by the receive-side frame checker.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frm_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;
    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment leaves the
// count at one so the event in that cycle is not lost.
module uart_sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? CNT_ONE : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uart_frame_check.sv
// UART RX frame checker: assembles data bits from sampler strobes and flags parity
// and stop errors. Error counters exist only with UART_FRAME_CHECK_ERR_CNT_EN defined.
module uart_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  frm_start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] frm_data,
    output logic                  frm_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  par_err_sticky,
    output logic                  stp_err_sticky,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
    localparam logic STP_LAST = 1'(STOP_BITS - STOP_BITS_MIN);

    frm_state_t            state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  stp_cnt_q, stp_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_run_q, par_run_d;
    logic                  par_en_l_q, par_en_l_d;
    logic                  par_typ_l_q, par_typ_l_d;
    logic                  par_fail_q, par_fail_d;
    logic                  stp_fail_q, stp_fail_d;
    logic [DATA_WIDTH-1:0] frm_data_q, frm_data_d;
    logic                  frm_valid_q, frm_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  par_sticky_q, par_sticky_d;
    logic                  stp_sticky_q, stp_sticky_d;

    logic                  frame_done;
    logic                  frame_par_err;
    logic                  frame_stp_err;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        stp_cnt_d     = stp_cnt_q;
        shift_d       = shift_q;
        par_run_d     = par_run_q;
        par_en_l_d    = par_en_l_q;
        par_typ_l_d   = par_typ_l_q;
        par_fail_d    = par_fail_q;
        stp_fail_d    = stp_fail_q;
        frm_data_d    = frm_data_q;
        frm_valid_d   = 1'b0;
        par_err_d     = par_err_q;
        stp_err_d     = stp_err_q;
        frame_done    = 1'b0;
        frame_par_err = par_en_l_q & par_fail_q;
        frame_stp_err = stp_fail_q | ~sampled_bit;

        // A start always wins: it re-arms the frame and discards any strobe in the same cycle.
        if (frm_start) begin
            state_d     = ST_DATA;
            bit_cnt_d   = '0;
            stp_cnt_d   = 1'b0;
            par_run_d   = 1'b0;
            par_en_l_d  = par_en;
            par_typ_l_d = par_typ;
            par_fail_d  = 1'b0;
            stp_fail_d  = 1'b0;
        end else if (bit_valid) begin
            case (state_q)
                ST_DATA: begin
                    shift_d[bit_cnt_q] = sampled_bit;
                    par_run_d          = par_run_q ^ sampled_bit;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_l_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    par_fail_d = par_run_q ^ sampled_bit ^ (par_typ_l_q == PAR_ODD);
                    state_d    = ST_STOP;
                end
                ST_STOP: begin
                    if (!sampled_bit) begin
                        stp_fail_d = 1'b1;
                    end
                    if (stp_cnt_q == STP_LAST) begin
                        state_d     = ST_IDLE;
                        frame_done  = 1'b1;
                        frm_valid_d = 1'b1;
                        frm_data_d  = shift_q;
                        par_err_d   = frame_par_err;
                        stp_err_d   = frame_stp_err;
                    end else begin
                        stp_cnt_d = stp_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        par_sticky_d = (err_clr ? 1'b0 : par_sticky_q) | (frame_done & frame_par_err);
        stp_sticky_d = (err_clr ? 1'b0 : stp_sticky_q) | (frame_done & frame_stp_err);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            stp_cnt_q    <= 1'b0;
            shift_q      <= '0;
            par_run_q    <= 1'b0;
            par_en_l_q   <= 1'b0;
            par_typ_l_q  <= 1'b0;
            par_fail_q   <= 1'b0;
            stp_fail_q   <= 1'b0;
            frm_data_q   <= '0;
            frm_valid_q  <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            par_sticky_q <= 1'b0;
            stp_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            stp_cnt_q    <= stp_cnt_d;
            shift_q      <= shift_d;
            par_run_q    <= par_run_d;
            par_en_l_q   <= par_en_l_d;
            par_typ_l_q  <= par_typ_l_d;
            par_fail_q   <= par_fail_d;
            stp_fail_q   <= stp_fail_d;
            frm_data_q   <= frm_data_d;
            frm_valid_q  <= frm_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            par_sticky_q <= par_sticky_d;
            stp_sticky_q <= stp_sticky_d;
        end
    end

    assign frm_data       = frm_data_q;
    assign frm_valid      = frm_valid_q;
    assign par_err        = par_err_q;
    assign stp_err        = stp_err_q;
    assign par_err_sticky = par_sticky_q;
    assign stp_err_sticky = stp_sticky_q;

`ifdef UART_FRAME_CHECK_ERR_CNT_EN
    logic par_inc;
    logic stp_inc;

    assign par_inc = frame_done & frame_par_err;
    assign stp_inc = frame_done & frame_stp_err;

    uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (par_inc),
        .clr   (err_clr),
        .count (par_err_cnt)
    );

    uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stp_inc),
        .clr   (err_clr),
        .count (stp_err_cnt)
    );
`else
    assign par_err_cnt = '0;
    assign stp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_frame_check.sv
// Randomized bench for uart_frame_check: instance 0 has one stop bit and 8-bit counters,
// instance 1 has two stop bits and 2-bit counters; both checked against a frame-level model.
module tb_uart_frame_check;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] frm_start   = '0;
    logic [1:0] bit_valid   = '0;
    logic [1:0] sampled_bit = '0;
    logic [1:0] par_en      = '0;
    logic [1:0] par_typ     = '0;
    logic [1:0] err_clr     = '0;

    logic [7:0] fd_a, fd_b;
    logic       fv_a, fv_b, pe_a, pe_b, se_a, se_b;
    logic       ps_a, ps_b, ss_a, ss_b;
    logic [7:0] pc_a, sc_a;
    logic [1:0] pc_b, sc_b;

    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) u_dut_a (
        .CLK(clk), .RST(rst_n),
        .frm_start(frm_start[0]), .bit_valid(bit_valid[0]), .sampled_bit(sampled_bit[0]),
        .par_en(par_en[0]), .par_typ(par_typ[0]), .err_clr(err_clr[0]),
        .frm_data(fd_a), .frm_valid(fv_a), .par_err(pe_a), .stp_err(se_a),
        .par_err_sticky(ps_a), .stp_err_sticky(ss_a),
        .par_err_cnt(pc_a), .stp_err_cnt(sc_a)
    );

    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(2)) u_dut_b (
        .CLK(clk), .RST(rst_n),
        .frm_start(frm_start[1]), .bit_valid(bit_valid[1]), .sampled_bit(sampled_bit[1]),
        .par_en(par_en[1]), .par_typ(par_typ[1]), .err_clr(err_clr[1]),
        .frm_data(fd_b), .frm_valid(fv_b), .par_err(pe_b), .stp_err(se_b),
        .par_err_sticky(ps_b), .stp_err_sticky(ss_b),
        .par_err_cnt(pc_b), .stp_err_cnt(sc_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference model, one slot per instance.
    logic [7:0] m_data[2];
    bit         m_perr[2], m_serr[2], m_psticky[2], m_ssticky[2];
    int         m_pcnt[2], m_scnt[2];
    int         m_nvalid[2] = '{0, 0};
    int         obs_nvalid[2] = '{0, 0};
    bit         m_busy[2] = '{0, 0};
    int         sb[2] = '{1, 2};
    int         cmax[2] = '{255, 3};

    always @(negedge clk) begin
        if (fv_a) obs_nvalid[0]++;
        if (fv_b) obs_nvalid[1]++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef UART_FRAME_CHECK_ERR_CNT_EN
        return 32'(v);
`else
        return (v < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_data[i] = '0; m_perr[i] = 0; m_serr[i] = 0;
            m_psticky[i] = 0; m_ssticky[i] = 0; m_pcnt[i] = 0; m_scnt[i] = 0;
            m_busy[i] = 0;
        end
    endtask

    task automatic check_outputs(input int i, input string tag, input bit exp_valid);
        logic [7:0] d, pc, sc;
        logic       v, pe, se, ps, ss;
        if (i == 0) begin
            d = fd_a; v = fv_a; pe = pe_a; se = se_a; ps = ps_a; ss = ss_a; pc = pc_a; sc = sc_a;
        end else begin
            d = fd_b; v = fv_b; pe = pe_b; se = se_b; ps = ps_b; ss = ss_b;
            pc = {6'd0, pc_b}; sc = {6'd0, sc_b};
        end
        check_eq($sformatf("%s/u%0d frm_valid", tag, i), 32'(v), 32'(exp_valid));
        check_eq($sformatf("%s/u%0d frm_data", tag, i), 32'(d), 32'(m_data[i]));
        check_eq($sformatf("%s/u%0d par_err", tag, i), 32'(pe), 32'(m_perr[i]));
        check_eq($sformatf("%s/u%0d stp_err", tag, i), 32'(se), 32'(m_serr[i]));
        check_eq($sformatf("%s/u%0d par_sticky", tag, i), 32'(ps), 32'(m_psticky[i]));
        check_eq($sformatf("%s/u%0d stp_sticky", tag, i), 32'(ss), 32'(m_ssticky[i]));
        check_eq($sformatf("%s/u%0d par_cnt", tag, i), 32'(pc), exp_cnt(m_pcnt[i]));
        check_eq($sformatf("%s/u%0d stp_cnt", tag, i), 32'(sc), exp_cnt(m_scnt[i]));
    endtask

    task automatic idle_junk(input int i, input int n);
        repeat (n) begin
            bit_valid[i] = 1'($urandom);
            sampled_bit[i] = 1'($urandom);
            @(negedge clk);
        end
        bit_valid[i] = 1'b0;
    endtask

    task automatic pulse_clr(input int i);
        err_clr[i] = 1'b1;
        @(negedge clk);
        err_clr[i] = 1'b0;
        m_psticky[i] = 0; m_ssticky[i] = 0; m_pcnt[i] = 0; m_scnt[i] = 0;
        check_outputs(i, "clr", 1'b0);
    endtask

    // Sends one frame; abort_at >= 0 stops before that bit position, leaving the frame open.
    task automatic send_frame(input int i, input string tag, input logic [7:0] data,
                              input bit pen, input bit ptyp, input bit pbit,
                              input bit [1:0] stops, input bit clr_last, input int abort_at);
        int  total;
        bit  val, perr, serr;
        total = 8 + (pen ? 1 : 0) + sb[i];
        frm_start[i] = 1'b1;
        bit_valid[i] = 1'($urandom);
        sampled_bit[i] = 1'($urandom);
        par_en[i] = pen;
        par_typ[i] = ptyp;
        @(negedge clk);
        frm_start[i] = 1'b0;
        bit_valid[i] = 1'b0;
        par_en[i] = 1'($urandom);
        par_typ[i] = 1'($urandom);
        check_outputs(i, {tag, "/start"}, 1'b0);
        for (int p = 0; p < total; p++) begin
            if (p == abort_at) begin
                bit_valid[i] = 1'b0;
                m_busy[i] = 1;
                return;
            end
            repeat ($urandom_range(0, 1)) begin
                bit_valid[i] = 1'b0;
                sampled_bit[i] = 1'($urandom);
                @(negedge clk);
            end
            if (p < 8)                 val = data[p];
            else if (pen && p == 8)    val = pbit;
            else                       val = stops[p - 8 - (pen ? 1 : 0)];
            bit_valid[i] = 1'b1;
            sampled_bit[i] = val;
            if (p == total - 1) err_clr[i] = clr_last;
            @(negedge clk);
        end
        bit_valid[i] = 1'b0;
        err_clr[i] = 1'b0;
        m_busy[i] = 0;
        perr = pen && ((($countones(data) + int'(pbit)) % 2) != (ptyp ? 1 : 0));
        serr = (stops[0] == 1'b0) || (sb[i] == 2 && stops[1] == 1'b0);
        m_data[i] = data;
        m_perr[i] = perr;
        m_serr[i] = serr;
        m_nvalid[i]++;
        if (clr_last) begin
            m_psticky[i] = perr; m_ssticky[i] = serr;
            m_pcnt[i] = int'(perr); m_scnt[i] = int'(serr);
        end else begin
            m_psticky[i] |= perr; m_ssticky[i] |= serr;
            if (perr && m_pcnt[i] < cmax[i]) m_pcnt[i]++;
            if (serr && m_scnt[i] < cmax[i]) m_scnt[i]++;
        end
        check_outputs(i, tag, 1'b1);
        @(negedge clk);
        check_eq($sformatf("%s/u%0d pulse_end", tag, i), 32'(i == 0 ? fv_a : fv_b), 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs(0, "reset", 1'b0);
        check_outputs(1, "reset", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        idle_junk(0, 4);
        send_frame(0, "a5", 8'hA5, 0, 0, 0, 2'b11, 0, -1);
        check_eq("a5 literal", 32'(fd_a), 32'hA5);
        send_frame(0, "par_even", 8'h03, 1, 0, 1, 2'b11, 0, -1);
        check_eq("par_even literal", 32'(pe_a), 32'd1);
        send_frame(0, "par_odd", 8'h03, 1, 1, 1, 2'b11, 0, -1);
        send_frame(1, "stop2_bad", 8'h81, 0, 0, 0, 2'b01, 0, -1);
        check_eq("stop2 literal", 32'(se_b), 32'd1);
        send_frame(1, "stop2_good", 8'h7E, 0, 0, 0, 2'b11, 0, -1);
        send_frame(0, "abort", 8'hFF, 0, 0, 0, 2'b00, 0, 4);
        send_frame(0, "after_abort", 8'h3C, 0, 0, 0, 2'b11, 0, -1);
        check_eq("abort literal", 32'(fd_a), 32'h3C);
        for (int k = 0; k < 5; k++)
            send_frame(1, $sformatf("sat%0d", k), 8'(k * 37), 0, 0, 0, 2'b10, 0, -1);
        send_frame(1, "sat_clr", 8'h11, 0, 0, 0, 2'b01, 1, -1);

        // Reset while both instances are mid-frame.
        send_frame(0, "rst_mid", 8'hC3, 0, 0, 0, 2'b11, 0, 4);
        send_frame(1, "rst_mid", 8'hC3, 1, 0, 0, 2'b11, 0, 6);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs(0, "rst_async", 1'b0);
        check_outputs(1, "rst_async", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(0, "post_rst", 8'h5A, 0, 0, 0, 2'b11, 0, -1);
        send_frame(1, "post_rst", 8'h5A, 1, 1, 1, 2'b11, 0, -1);

        // Randomized frames on both instances.
        for (int n = 0; n < 80; n++) begin
            int  i, total, ab;
            bit  pen;
            i = n % 2;
            pen = 1'($urandom);
            total = 8 + (pen ? 1 : 0) + sb[i];
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, total - 1)) : -1;
            if (!m_busy[i]) idle_junk(i, $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0 && !m_busy[i]) pulse_clr(i);
            send_frame(i, $sformatf("rnd%0d", n), 8'($urandom), pen, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11,
                       ($urandom_range(0, 9) == 0), ab);
        end
        send_frame(0, "final", 8'h96, 1, 1, 1, 2'b11, 0, -1);
        send_frame(1, "final", 8'h69, 1, 0, 0, 2'b11, 0, -1);

        repeat (2) @(negedge clk);
        check_eq("u0 valid_count", 32'(obs_nvalid[0]), 32'(m_nvalid[0]));
        check_eq("u1 valid_count", 32'(obs_nvalid[1]), 32'(m_nvalid[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
